db4_dwt_sched: RTL and testbench
================================

# db4_dwt_sched

Multi-octave scheduler for the Daubechies-4 lattice analysis datapath. It accepts a sample stream, splits it into even/odd pairs per octave, and time-shares one external two-stage lattice engine across `LEVELS` octaves. The engine's lowpass result feeds the next octave. The block emits detail coefficients per octave, plus the final approximation, on a valid/ready output. It sits between the ADC-side sample source and the coefficient sink, in front of the shared lattice core.

## Interface
- `LEVELS`, 3: number of octaves; range 1..4.
- `DW`, 9: word width for samples, engine operands and results; signed two's complement.

- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample.
- `x_in`  in  DW  input sample; upstream sign-extends it.
- `lat_start`  out  1  one-cycle pulse that launches the engine.
- `lat_even`  out  DW  earlier sample of the pair; held stable from `lat_start` until `lat_done`.
- `lat_odd`  out  DW  later sample of the pair; held stable from `lat_start` until `lat_done`.
- `lat_level`  out  2  octave index of the launched pair.
- `lat_done`  in  1  one-cycle pulse; `lat_g` and `lat_h` are valid in this cycle.
- `lat_g`  in  DW  engine lowpass result.
- `lat_h`  in  DW  engine highpass result.
- `out_valid`  out  1  coefficient valid.
- `out_ready`  in  1  sink accepts the coefficient.
- `out_data`  out  DW  coefficient value.
- `out_level`  out  2  octave of the coefficient.
- `out_is_approx`  out  1  1 = final approximation; 0 = detail.
- `err`  out  1  sticky protocol error flag (see Configuration).

## Operation
- **Per-octave pair buffer.** Each octave k has a buffer of two words plus `cnt_k` (0..2).
  - Writes land at index `cnt_k`.
  - The pair is ready when `cnt_k == 2`.
  - Octave 0 is written from `x_in` on each `in_valid & in_ready`.
  - Octave k>0 is written from the `lat_g` result of octave k-1.
- **Input flow control.** `in_ready = (cnt_0 != 2)`, except during reset.
- **Arbitration.** Fixed priority: highest ready octave index wins (deepest first). This guarantees octave k+1 has free space whenever an octave-k result returns.
- **FSM states:**
  - `IDLE`: if any octave is ready, register the winner into `sel`, load its buffer into `lat_even`/`lat_odd`, and go to `ISSUE`.
  - `ISSUE`: assert `lat_start` for one cycle, clear `cnt_sel` to 0, go to `WAIT`.
  - `WAIT`: on `lat_done`, capture `lat_g` and `lat_h`, go to `EMIT_D`.
  - `EMIT_D`: present the `h` coefficient with `out_is_approx=0` and `out_level=sel`. On `out_ready`:
    - if `sel < LEVELS-1`, write `g` into octave `sel+1` and go to `IDLE`;
    - otherwise go to `EMIT_A`.
  - `EMIT_A`: present `g` with `out_is_approx=1` and `out_level=LEVELS-1`. On `out_ready`, go to `IDLE`.
- **Output stability.** While `out_valid=1` and `out_ready=0`, all output fields hold stable. No new engine launch happens while a result is unacknowledged.
- **Width rules.** No arithmetic in this block. Words pass through unmodified at `DW` bits, with no truncation or extension.

## Timing
- **Reset values:**
  - all `cnt_k` = 0, state = `IDLE`;
  - `in_ready` = 0 while `reset` = 0, and 1 from the first clock after release;
  - `lat_start`, `out_valid`, `err` = 0;
  - `lat_even`, `lat_odd`, `out_data` = 0;
  - `lat_level`, `out_level`, `out_is_approx` = 0.
- **Latency.**
  - Second sample of a pair accepted at edge N → `lat_start` high in cycle N+2.
  - `lat_done` at edge M → `out_valid` in cycle M+1.
- **Minimum dispatch spacing.** 4 cycles plus engine latency.
- **Input vs. ISSUE on octave 0.** `in_ready` is 0 while `cnt_0 == 2`, so an input accept cannot collide with the `ISSUE` clear. `in_ready` returns to 1 the cycle after `ISSUE`.
- **Reset mid-operation.** Asserting `reset` at any point, including in `WAIT`, empties all buffers and returns to `IDLE` immediately. A `lat_done` arriving after release while in `IDLE` is ignored.

## Configuration
- `DB4_SCHED_ERR_EN` defined:
  - `err` sets and stays set until reset on either of two events:
    - `lat_done` in any state other than `WAIT`;
    - a `g` write into an octave whose `cnt` is 2.
  - On an overflowing write, the write is dropped.
- `DB4_SCHED_ERR_EN` undefined: `err` is tied to 0 and the checking logic is absent. Functional behaviour is otherwise identical.

## Test plan
- **Reset values.** Hold `reset=0` for 3 cycles, then release → all outputs at their reset values, and `in_ready=1` one cycle after release.
- **Single level-0 pair.** `LEVELS=3`, engine echoes `g=even+odd`, `h=even-odd`. Feed `x_in` 10 then 4 → `lat_start` with `lat_even`=10 and `lat_odd`=4, then output `h=6`, level 0, `is_approx=0`.
- **Full tree, 8 samples.** Feed samples 1..8 with the echo engine. Required output sequence:
  - level 0: `h` = −1, −1, −1, −1;
  - level 1: `h` = −4, −4;
  - level 2: `h` = −16;
  - approximation: 36, level 2, `is_approx=1`.
  - Deeper octaves must be dispatched before later level-0 pairs once ready.
- **Backpressure.** Hold `out_ready=0` for 10 cycles during `EMIT_D` → `out_data` stays stable, no `lat_start`, and `in_ready` drops once `cnt_0` reaches 2. Releasing resumes with no loss.
- **Reset in `WAIT`.** Assert `reset` in `WAIT`, then release and pulse `lat_done` → no `out_valid`, and `err=0` with the macro undefined.
- **Error flag.** With `DB4_SCHED_ERR_EN`, pulse `lat_done` while in `IDLE` → `err=1` and it stays set until reset.

Source files
------------

// File: rtl/db4_dwt_sched_if.sv
// Port bundle for db4_dwt_sched: sample input, lattice-engine handshake and coefficient output.
// The scheduler takes the slave view; the surrounding system (source, engine, sink) the master.
interface db4_dwt_sched_if #(
    parameter int unsigned DW = 9
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x_in;

    logic          lat_start;
    logic [DW-1:0] lat_even;
    logic [DW-1:0] lat_odd;
    logic [1:0]    lat_level;
    logic          lat_done;
    logic [DW-1:0] lat_g;
    logic [DW-1:0] lat_h;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_level;
    logic          out_is_approx;

    logic          err;

    modport slave (
        input  in_valid, x_in, lat_done, lat_g, lat_h, out_ready,
        output in_ready, lat_start, lat_even, lat_odd, lat_level,
               out_valid, out_data, out_level, out_is_approx, err
    );

    modport master (
        output in_valid, x_in, lat_done, lat_g, lat_h, out_ready,
        input  in_ready, lat_start, lat_even, lat_odd, lat_level,
               out_valid, out_data, out_level, out_is_approx, err
    );

endinterface

// File: rtl/db4_dwt_sched.sv
// Multi-octave DB4 scheduler: per-octave even/odd pair buffers sharing one external lattice
// engine, deepest ready octave first. Define DB4_SCHED_ERR_EN to enable the sticky err flag.
module db4_dwt_sched #(
    parameter int unsigned LEVELS = 3,
    parameter int unsigned DW     = 9
) (
    input logic            clk,
    input logic            reset,
    db4_dwt_sched_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] EMIT_D = 3'd3;
    localparam logic [2:0] EMIT_A = 3'd4;

    localparam logic [1:0] LAST = 2'(LEVELS - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        cnt_q  [LEVELS];
    logic [DW-1:0]     pair_q [LEVELS][2];
    logic [1:0]        sel_q;
    logic [DW-1:0]     even_q, odd_q;
    logic [DW-1:0]     g_q, h_q;
    logic              rdy_q;

    logic              any_ready;
    logic [1:0]        win;
    logic              in_fire;
    logic              g_fire;
    logic              sel_last;
    logic [LEVELS-1:0] wr_en;
    logic [LEVELS-1:0] clr_en;

    assign sel_last = (sel_q == LAST);
    assign in_fire  = bus.in_valid & bus.in_ready;
    // Lowpass result moves one octave down when the detail coefficient is acknowledged.
    assign g_fire   = (state_q == EMIT_D) & bus.out_ready & ~sel_last;

    // Later (deeper) ready octaves overwrite earlier ones, so the deepest wins.
    always_comb begin
        any_ready = 1'b0;
        win       = '0;
        for (int k = 0; k < LEVELS; k++) begin
            if (cnt_q[k] == 2'd2) begin
                any_ready = 1'b1;
                win       = 2'(k);
            end
        end
    end

    always_comb begin
        wr_en    = '0;
        clr_en   = '0;
        wr_en[0] = in_fire;
        for (int k = 0; k < LEVELS; k++) begin
            clr_en[k] = (state_q == ISSUE) && (sel_q == 2'(k));
        end
        for (int k = 1; k < LEVELS; k++) begin
            if (g_fire && (sel_q == 2'(k - 1))) begin
`ifdef DB4_SCHED_ERR_EN
                wr_en[k] = (cnt_q[k] != 2'd2);
`else
                wr_en[k] = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_ready) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.lat_done) state_d = EMIT_D;
            EMIT_D:  if (bus.out_ready) state_d = sel_last ? EMIT_A : IDLE;
            EMIT_A:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LEVELS; k++) begin
                cnt_q[k]     <= '0;
                pair_q[k][0] <= '0;
                pair_q[k][1] <= '0;
            end
        end else begin
            for (int k = 0; k < LEVELS; k++) begin
                if (clr_en[k]) begin
                    cnt_q[k] <= '0;
                end else if (wr_en[k]) begin
                    pair_q[k][cnt_q[k][0]] <= (k == 0) ? bus.x_in : g_q;
                    cnt_q[k]               <= cnt_q[k] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            sel_q   <= '0;
            even_q  <= '0;
            odd_q   <= '0;
            g_q     <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if ((state_q == IDLE) && any_ready) begin
                sel_q  <= win;
                even_q <= pair_q[win][0];
                odd_q  <= pair_q[win][1];
            end
            if ((state_q == WAIT) && bus.lat_done) begin
                g_q <= bus.lat_g;
                h_q <= bus.lat_h;
            end
        end
    end

`ifdef DB4_SCHED_ERR_EN
    logic              err_q;
    logic              ovf_any;
    logic              stray_done;

    always_comb begin
        ovf_any = 1'b0;
        for (int k = 1; k < LEVELS; k++) begin
            if (g_fire && (sel_q == 2'(k - 1)) && (cnt_q[k] == 2'd2)) begin
                ovf_any = 1'b1;
            end
        end
    end

    assign stray_done = bus.lat_done && (state_q != WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (stray_done || ovf_any) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // cnt_0 == 2 only clears at the ISSUE edge, so input can never collide with the clear.
    assign bus.in_ready      = rdy_q && (cnt_q[0] != 2'd2);

    assign bus.lat_start     = (state_q == ISSUE);
    assign bus.lat_even      = even_q;
    assign bus.lat_odd       = odd_q;
    assign bus.lat_level     = sel_q;

    assign bus.out_valid     = (state_q == EMIT_D) || (state_q == EMIT_A);
    assign bus.out_data      = (state_q == EMIT_A) ? g_q : h_q;
    assign bus.out_level     = (state_q == EMIT_A) ? LAST : sel_q;
    assign bus.out_is_approx = (state_q == EMIT_A);

endmodule

// File: tb/tb_db4_dwt_sched.sv
// Self-checking bench for db4_dwt_sched: directed cases plus a randomized stream checked against a
// dataflow model of the octave tree and an echo engine (g = even + odd, h = even - odd).
module tb_db4_dwt_sched;

    localparam int unsigned LEVELS = 3;
    localparam int unsigned DW     = 9;
    localparam int unsigned NRAND  = 256;
    localparam int TreeDet [3][4] = '{'{-1, -1, -1, -1}, '{-4, -4, 0, 0}, '{-16, 0, 0, 0}};
    localparam int TreeCnt [3]    = '{4, 2, 1};
`ifdef DB4_SCHED_ERR_EN
    localparam logic ExpErr = 1'b1;
`else
    localparam logic ExpErr = 1'b0;
`endif

    typedef logic [DW-1:0] word_t;
    typedef struct packed {
        word_t      data;
        logic [1:0] level;
        logic       approx;
    } out_t;

    logic  clk   = 1'b0;
    logic  reset = 1'b1;
    always #5 clk = ~clk;

    logic  drv_valid = 1'b0;
    word_t drv_x     = '0;
    logic  drv_ready = 1'b0;
    logic  rnd_ready = 1'b1;
    logic  rand_mode = 1'b0;
    logic  man_done  = 1'b0;
    logic  eng_en    = 1'b1;
    logic  eng_done  = 1'b0;
    word_t eng_g     = '0;
    word_t eng_h     = '0;

    db4_dwt_sched_if #(.DW(DW)) bus ();

    assign bus.in_valid  = drv_valid;
    assign bus.x_in      = drv_x;
    assign bus.out_ready = rand_mode ? rnd_ready : drv_ready;
    assign bus.lat_done  = eng_done | man_done;
    assign bus.lat_g     = eng_g;
    assign bus.lat_h     = eng_h;

    db4_dwt_sched #(.LEVELS(LEVELS), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic word_t wv(input int v);
        return word_t'(v);
    endfunction

    // Reference model: pure dataflow of the octave tree, independent of timing.
    word_t lvl_q [LEVELS][$];
    word_t det_q [LEVELS][$];
    word_t evn_q [LEVELS][$];
    word_t odd_q [LEVELS][$];
    word_t apx_q [$];
    out_t  log_q [$];
    int    delivered [LEVELS];
    int    launched  [LEVELS];
    int    n_app, done_cyc, ov_cyc;

    function automatic void feed(input word_t v);
        word_t cur, e, o;
        cur = v;
        for (int k = 0; k < LEVELS; k++) begin
            lvl_q[k].push_back(cur);
            if (lvl_q[k].size() < 2) return;
            e = lvl_q[k].pop_front();
            o = lvl_q[k].pop_front();
            evn_q[k].push_back(e);
            odd_q[k].push_back(o);
            det_q[k].push_back(e - o);
            cur = e + o;
        end
        apx_q.push_back(cur);
    endfunction

    function automatic int pend(input int k);
        return delivered[k] - 2 * launched[k];
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < LEVELS; k++) begin
            lvl_q[k].delete();
            det_q[k].delete();
            evn_q[k].delete();
            odd_q[k].delete();
            delivered[k] = 0;
            launched[k]  = 0;
        end
        apx_q.delete();
        log_q.delete();
        n_app = 0;
    endfunction

    // Echo engine with random latency; also checks operands are held until done.
    initial begin : engine
        word_t e, o;
        forever begin
            @(negedge clk);
            if (eng_en && reset && bus.lat_start) begin
                e = bus.lat_even;
                o = bus.lat_odd;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                @(posedge clk); #1;
                eng_g    = e + o;
                eng_h    = e - o;
                eng_done = 1'b1;
                @(negedge clk);
                check_eq("lat_operand_hold", 32'({bus.lat_even, bus.lat_odd}), 32'({e, o}));
                @(posedge clk); #1;
                eng_done = 1'b0;
            end
        end
    end

    initial begin : ready_gen
        int hold;
        hold = 0;
        forever begin
            @(posedge clk); #1;
            if (hold > 0) begin
                hold--;
                rnd_ready = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                hold      = int'($urandom_range(3, 12));
                rnd_ready = 1'b0;
            end else begin
                rnd_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin : monitor
        logic [1:0] lv;
        bit         deep, rel, prev_hold, prev_ov;
        out_t       ent, prev;
        rel = 0; prev_hold = 0; prev_ov = 0; prev = '0;
        model_clear();
        forever begin
            @(negedge clk);
            if (!reset) begin
                model_clear();
                rel = 0; prev_hold = 0; prev_ov = 0;
            end else begin
                check_eq("in_ready", 32'(bus.in_ready), 32'(rel && (pend(0) < 2)));
                if (bus.lat_start) begin
                    lv = bus.lat_level;
                    check_eq("no_start_while_out", 32'(bus.out_valid), 32'(0));
                    check_eq("lat_level_range", 32'(lv < LEVELS), 32'(1));
                    if (lv < LEVELS) begin
                        check_eq("arb_own_ready", 32'(pend(int'(lv)) >= 2), 32'(1));
                        deep = 0;
                        for (int j = int'(lv) + 1; j < LEVELS; j++) if (pend(j) >= 2) deep = 1;
                        check_eq("arb_deepest", 32'(deep), 32'(0));
                        check_eq("pair_avail", 32'(evn_q[lv].size() > 0), 32'(1));
                        if (evn_q[lv].size() > 0) begin
                            check_eq("lat_even", 32'(bus.lat_even), 32'(evn_q[lv].pop_front()));
                            check_eq("lat_odd", 32'(bus.lat_odd), 32'(odd_q[lv].pop_front()));
                        end
                        launched[lv]++;
                    end
                end
                if (bus.lat_done) done_cyc = cyc;
                if (bus.out_valid && !prev_ov) ov_cyc = cyc;
                if (prev_hold) begin
                    check_eq("out_hold", 32'({bus.out_valid, bus.out_data, bus.out_level,
                             bus.out_is_approx}), 32'({1'b1, prev}));
                end
                ent = '{data: bus.out_data, level: bus.out_level, approx: bus.out_is_approx};
                if (bus.out_valid && bus.out_ready) begin
                    log_q.push_back(ent);
                    if (bus.out_is_approx) begin
                        n_app++;
                        check_eq("approx_level", 32'(bus.out_level), LEVELS - 1);
                        check_eq("approx_avail", 32'(apx_q.size() > 0), 32'(1));
                        if (apx_q.size() > 0)
                            check_eq("approx_data", 32'(bus.out_data), 32'(apx_q.pop_front()));
                    end else begin
                        lv = bus.out_level;
                        check_eq("detail_level_range", 32'(lv < LEVELS), 32'(1));
                        if (lv < LEVELS) begin
                            check_eq("detail_avail", 32'(det_q[lv].size() > 0), 32'(1));
                            if (det_q[lv].size() > 0)
                                check_eq("detail_data", 32'(bus.out_data),
                                         32'(det_q[lv].pop_front()));
                            if (lv < LEVELS - 1) delivered[lv + 1]++;
                        end
                    end
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                prev      = ent;
                prev_ov   = bus.out_valid;
                if (bus.in_valid && bus.in_ready) begin
                    feed(bus.x_in);
                    delivered[0]++;
                end
                rel = 1;
            end
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        drv_valid = 1'b0;
        reset     = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic send(input word_t v, output int acc);
        bit ok;
        ok        = 0;
        acc       = 0;
        drv_valid = 1'b1;
        drv_x     = v;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok  = 1;
                acc = cyc;
            end
            tick();
        end
        drv_valid = 1'b0;
        check_eq("send_accepted", 32'(ok), 32'(1));
    endtask

    // Returns at the negedge where the signal is seen (0: lat_start, 1: out_valid).
    task automatic wait_sig(input int which);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? bus.lat_start : bus.out_valid;
        end
        check_eq((which == 0) ? "saw_lat_start" : "saw_out_valid", 32'(seen), 32'(1));
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 1000 && log_q.size() < n; i++) tick();
        check_eq("log_count", 32'(log_q.size() >= n), 32'(1));
    endtask

    initial begin : driver
        int acc, starts;
        int idx [3];
        #1 reset = 1'b0;

        // Reset values
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_in_ready", 32'(bus.in_ready), 32'(0));
            check_eq("rst_ctrl", 32'({bus.lat_start, bus.out_valid, bus.err, bus.out_is_approx}),
                     32'(0));
            check_eq("rst_data", 32'({bus.lat_even, bus.lat_odd, bus.out_data}), 32'(0));
            check_eq("rst_level", 32'({bus.lat_level, bus.out_level}), 32'(0));
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_eq("rel_in_ready_pre", 32'(bus.in_ready), 32'(0));
        tick();
        @(negedge clk);
        check_eq("rel_in_ready", 32'(bus.in_ready), 32'(1));
        tick();

        // Single level-0 pair with latency checks
        drv_ready = 1'b1;
        send(wv(10), acc);
        send(wv(4), acc);
        wait_sig(0);
        check_eq("pair_start_latency", 32'(cyc - acc), 32'(2));
        check_eq("pair_even_odd", 32'({bus.lat_even, bus.lat_odd, bus.lat_level}),
                 32'({wv(10), wv(4), 2'd0}));
        wait_sig(1);
        check_eq("done_to_valid", 32'(cyc - done_cyc), 32'(1));
        check_eq("pair_out", 32'({bus.out_data, bus.out_level, bus.out_is_approx}),
                 32'({wv(6), 2'd0, 1'b0}));
        tick();

        // Full tree from samples 1..8
        do_reset(2);
        for (int s = 1; s <= 8; s++) send(wv(s), acc);
        wait_log(8);
        idx = '{0, 0, 0};
        foreach (log_q[i]) begin
            if (log_q[i].approx) begin
                check_eq("tree_approx", 32'({log_q[i].level, log_q[i].data}), 32'({2'd2, wv(36)}));
            end else if (log_q[i].level < 3 && idx[log_q[i].level] < TreeCnt[log_q[i].level]) begin
                check_eq("tree_detail", 32'(log_q[i].data),
                         32'(wv(TreeDet[log_q[i].level][idx[log_q[i].level]])));
                idx[log_q[i].level]++;
            end else begin
                check_eq("tree_extra_detail", 32'(log_q[i].level), 32'(3));
            end
        end
        for (int k = 0; k < 3; k++) check_eq("tree_detail_count", 32'(idx[k]), 32'(TreeCnt[k]));

        // Backpressure
        do_reset(2);
        drv_ready = 1'b0;
        send(wv(10), acc);
        send(wv(4), acc);
        wait_sig(1);
        tick();
        send(wv(1), acc);
        send(wv(2), acc);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_hold", 32'({bus.out_valid, bus.out_data}), 32'({1'b1, wv(6)}));
            check_eq("bp_in_ready", 32'(bus.in_ready), 32'(0));
            starts += int'(bus.lat_start);
            tick();
        end
        check_eq("bp_no_start", 32'(starts), 32'(0));
        drv_ready = 1'b1;
        wait_log(3);
        if (log_q.size() >= 3) begin
            check_eq("bp_log0", 32'({log_q[0].approx, log_q[0].level, log_q[0].data}),
                     32'({1'b0, 2'd0, wv(6)}));
            check_eq("bp_log1", 32'({log_q[1].approx, log_q[1].level, log_q[1].data}),
                     32'({1'b0, 2'd0, wv(-1)}));
            check_eq("bp_log2", 32'({log_q[2].approx, log_q[2].level, log_q[2].data}),
                     32'({1'b0, 2'd1, wv(11)}));
        end

        // Reset while waiting on the engine
        do_reset(2);
        eng_en = 1'b0;
        send(wv(5), acc);
        send(wv(3), acc);
        wait_sig(0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rw_rst_ctrl", 32'({bus.lat_start, bus.out_valid, bus.in_ready}), 32'(0));
        check_eq("rw_rst_even", 32'({bus.lat_even, bus.lat_odd}), 32'(0));
        tick();
        reset = 1'b1;
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("rw_no_out", 32'({bus.out_valid, bus.lat_start}), 32'(0));
            tick();
        end
        check_eq("rw_err", 32'(bus.err), 32'(ExpErr));
        eng_en = 1'b1;

        // Stray done in IDLE and err stickiness
        do_reset(2);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        @(negedge clk);
        check_eq("err_set", 32'(bus.err), 32'(ExpErr));
        repeat (5) tick();
        @(negedge clk);
        check_eq("err_sticky", 32'(bus.err), 32'(ExpErr));
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("err_cleared", 32'(bus.err), 32'(0));
        tick();

        // Randomized stream with random engine latency and sink stalls
        do_reset(1);
        rand_mode = 1'b1;
        for (int i = 0; i < NRAND; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(word_t'($urandom), acc);
        end
        for (int i = 0; i < 20000 && n_app < NRAND / 8; i++) tick();
        check_eq("rand_approx_count", 32'(n_app), NRAND / 8);
        repeat (4) tick();
        check_eq("rand_model_drained", 32'(det_q[0].size() + det_q[1].size() + det_q[2].size() +
                 apx_q.size()), 32'(0));
        check_eq("rand_err_clean", 32'(bus.err), 32'(0));
        rand_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
